bcd_conv_scheduler: RTL and testbench

- Shares one iterative double-dabble binary-to-BCD engine among NREQ requesters.
- A round-robin arbiter accepts one request at a time over a valid/ready handshake.
- An FSM runs the engine's add-3 and shift steps for WIDTH bits, then returns the BCD result with the requester ID.
- Sits between the binary sources and the digit display/decode logic (d100/d10/d1 nibbles).

---
 rtl/bcd_conv_scheduler_if.sv | 28 ++
 rtl/bcd_conv_scheduler.sv | 143 ++++++++++++++
 tb/tb_bcd_conv_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_conv_scheduler_if.sv
// Request/response bundle between binary sources and the shared BCD converter.
interface bcd_conv_scheduler_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned IDW    = 2
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_bin;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [4*DIGITS-1:0]   rsp_bcd;
    logic                  rsp_ready;
    logic                  busy;

    // Converter side
    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_bcd, busy
    );

    // Requester/consumer side
    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_bcd, busy
    );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one iterative double-dabble binary-to-BCD engine.
module bcd_conv_scheduler #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned IDW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_conv_scheduler_if.slave  bus
);
    localparam int unsigned BCDW = 4 * DIGITS;
    localparam int unsigned SRW  = BCDW + WIDTH;
    localparam int unsigned IDW1 = IDW + 1;
    localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    id_reg;
    logic [CNTW-1:0]   cnt;
    logic [SRW-1:0]    sreg;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [BCDW-1:0]   rsp_bcd;

    logic              found;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    cand;
    logic [IDW1-1:0]   cand_sum;
    logic [IDW1-1:0]   win_inc;
    logic [IDW-1:0]    nxt_ptr;
    logic [WIDTH-1:0]  sel_bin;
    logic [BCDW-1:0]   adj_bcd;
    logic [SRW-1:0]    shifted;

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        cand_sum = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand_sum = {1'b0, ptr} + IDW1'(k);
            if (cand_sum >= IDW1'(NREQ)) begin
                cand_sum = cand_sum - IDW1'(NREQ);
            end
            cand = IDW'(cand_sum);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Winner's operand and the pointer value just past the winner
    always_comb begin
        sel_bin = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (win == IDW'(k)) begin
                sel_bin = bus.req_bin[k*WIDTH +: WIDTH];
            end
        end
        win_inc = {1'b0, win} + IDW1'(1);
        nxt_ptr = (win_inc >= IDW1'(NREQ)) ? '0 : IDW'(win_inc);
    end

    // Grant is only offered from IDLE and never while reset is asserted
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && !rst && found) begin
            bus.req_ready[win] = 1'b1;
        end
    end

    // Double-dabble datapath: per-digit add-3 and whole-register left shift
    always_comb begin
        adj_bcd = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (sreg[WIDTH + 4*d +: 4] >= 4'd5) begin
                adj_bcd[4*d +: 4] = sreg[WIDTH + 4*d +: 4] + 4'd3;
            end else begin
                adj_bcd[4*d +: 4] = sreg[WIDTH + 4*d +: 4];
            end
        end
        shifted = {sreg[SRW-2:0], 1'b0};
    end

    // Control FSM and registered response; rsp fields load on the final shift
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id_reg    <= '0;
            cnt       <= '0;
            sreg      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_bcd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sreg   <= {BCDW'(0), sel_bin};
                        id_reg <= win;
                        cnt    <= '0;
                        ptr    <= nxt_ptr;
                        state  <= ADJ;
                    end
                end
                ADJ: begin
                    sreg[SRW-1:WIDTH] <= adj_bcd;
                    state             <= SHIFT;
                end
                SHIFT: begin
                    sreg <= shifted;
                    cnt  <= cnt + CNTW'(1);
                    if (cnt == CNTW'(WIDTH - 1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_bcd   <= shifted[SRW-1:WIDTH];
                        rsp_id    <= id_reg;
                    end else begin
                        state <= ADJ;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_bcd   = rsp_bcd;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Self-checking bench for bcd_conv_scheduler: directed cases plus randomized traffic.
module tb_bcd_conv_scheduler;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned IDW    = 2;

    logic clk = 1'b0;
    logic rst;
    int checks   = 0;
    int failures = 0;
    int unsigned cycle_n = 0;
    int mptr = 0;
    logic [WIDTH-1:0] opnd [NREQ];

    bcd_conv_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS), .IDW(IDW)) bus ();

    bcd_conv_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_n <= cycle_n + 1;

    // Decimal digits of v, least significant digit in the low nibble
    function automatic logic [4*DIGITS-1:0] to_bcd(int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < int'(DIGITS); d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Expected winner: first valid requester from p upward, wrapping
    function automatic int pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(int i, logic [WIDTH-1:0] v);
        bus.req_valid[i] = 1'b1;
        bus.req_bin[i*WIDTH +: WIDTH] = v;
        opnd[i] = v;
    endtask

    // Serve one request end to end; hold = cycles of consumer backpressure in DONE
    task automatic do_job(input int hold, output int unsigned gcyc);
        int w;
        int n;
        w = pick(bus.req_valid, mptr);
        gcyc = cycle_n;
        if (w < 0) begin
            #1;
            chk("no_request_ready", 32'(bus.req_ready), 32'(0));
            return;
        end
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 50) begin
            cyc();
            #1;
            n++;
        end
        gcyc = cycle_n;
        chk("grant_onehot", 32'(bus.req_ready), 32'(1) << w);
        chk("grant_idle_busy", 32'(bus.busy), 32'(0));
        mptr = (w + 1) % NREQ;
        cyc();
        if (hold > 0) bus.rsp_ready = 1'b0;
        #1;
        chk("ready_after_grant", 32'(bus.req_ready), 32'(0));
        chk("busy_running", 32'(bus.busy), 32'(1));
        bus.req_valid[w] = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 60) begin
            cyc();
            n++;
        end
        chk("latency", 32'(n), 32'(17));
        chk("rsp_bcd", 32'(bus.rsp_bcd), 32'(to_bcd(32'(opnd[w]))));
        chk("rsp_id", 32'(bus.rsp_id), 32'(w));
        for (int i = 0; i < hold; i++) begin
            cyc();
            #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'(1));
            chk("hold_bcd", 32'(bus.rsp_bcd), 32'(to_bcd(32'(opnd[w]))));
            chk("hold_id", 32'(bus.rsp_id), 32'(w));
            chk("hold_no_grant", 32'(bus.req_ready), 32'(0));
        end
        bus.rsp_ready = 1'b1;
        cyc();
        chk("exit_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("exit_busy", 32'(bus.busy), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned g [4];
        int unsigned gx;
        logic bad;
        logic [NREQ-1:0] mask;

        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_bin   = '1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) opnd[i] = '0;

        // Reset state, with requests pending
        repeat (3) cyc();
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("rst_rsp_bcd", 32'(bus.rsp_bcd), 32'(0));
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
        bus.req_valid = '0;
        bus.req_bin   = '0;
        rst = 1'b0;
        mptr = 0;
        cyc();

        // Single request and boundary operands
        set_req(0, 8'd243); do_job(0, gx);
        set_req(0, 8'd0);   do_job(0, gx);
        set_req(0, 8'd255); do_job(0, gx);
        set_req(0, 8'd99);  do_job(0, gx);
        set_req(0, 8'd100); do_job(0, gx);

        // Reset in the middle of a conversion
        set_req(0, 8'd200);
        #1;
        chk("midrst_grant", 32'(bus.req_ready), 32'(1));
        cyc();
        bus.req_valid[0] = 1'b0;
        cyc();
        chk("midrst_busy_before", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        bus.req_valid = 4'b0110;
        cyc();
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("midrst_req_ready", 32'(bus.req_ready), 32'(0));
        rst = 1'b0;
        bus.req_valid = '0;
        mptr = 0;
        bad = 1'b0;
        repeat (40) begin
            cyc();
            if (bus.rsp_valid) bad = 1'b1;
        end
        chk("midrst_no_response", 32'(bad), 32'(0));

        // All four at once from pointer 0, consumer always ready
        set_req(0, 8'd10); set_req(1, 8'd20); set_req(2, 8'd30); set_req(3, 8'd40);
        for (int i = 0; i < 4; i++) do_job(0, g[i]);
        for (int i = 1; i < 4; i++) chk("spacing", g[i] - g[i-1], 32'(18));

        // Round-robin fairness: after req2 the pointer sits at 3
        set_req(2, 8'd55); do_job(0, gx);
        set_req(1, 8'd77); set_req(3, 8'd88);
        do_job(0, gx);
        do_job(0, gx);

        // Backpressure in DONE with another request pending
        set_req(0, 8'd123); set_req(1, 8'd45);
        do_job(10, g[0]);
        do_job(0, g[1]);
        chk("backpressure_spacing", g[1] - g[0], 32'(28));

        // Randomized traffic
        for (int r = 0; r < 15; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < int'(NREQ); i++) begin
                if (mask[i]) set_req(i, WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
            end
            while (bus.req_valid != '0) do_job(int'($urandom_range(0, 2)), gx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
